// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data cache share one memory with a
// single outstanding transaction. Define MEM_ARB_RR_EN for round-robin tie-break.
package PARAMS_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WD_SIZE   = 32;
endpackage

module mem_arbiter
  import PARAMS_pkg::*;
#(
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_req_valid,
  input  logic [ADDR_SIZE-1:0] ic_req_addr,
  output logic                 ic_req_ready,
  input  logic                 dc_req_valid,
  input  logic [ADDR_SIZE-1:0] dc_req_addr,
  input  logic                 dc_req_rd_wr,
  input  logic [WD_SIZE-1:0]   dc_req_wr_data,
  output logic                 dc_req_ready,
  output logic                 ic_resp_valid,
  output logic                 dc_resp_valid,
  output logic [WD_SIZE-1:0]   resp_data,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  input  logic [WD_SIZE-1:0]   mem_rd_data
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_e                 state_q, state_d;
  logic   [3:0]           cnt_q, cnt_d;
  owner_e                 owner_q, owner_d;
  logic   [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                   rd_wr_q, rd_wr_d;
  logic   [WD_SIZE-1:0]   wdata_q, wdata_d;
  logic   [WD_SIZE-1:0]   rdata_q, rdata_d;

  logic grant_dc;
  logic in_idle;
  logic busy;
  logic op_cycle;
  logic ic_acc;
  logic dc_acc;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    if (ic_req_valid && dc_req_valid) grant_dc = (last_q == OWN_IC);
    else                              grant_dc = dc_req_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_q <= OWN_IC;
    else if (dc_acc) last_q <= OWN_DC;
    else if (ic_acc) last_q <= OWN_IC;
  end
`else
  assign grant_dc = dc_req_valid;
`endif

  // Readies are forced low while reset is held so every output is quiet in reset.
  assign in_idle      = (state_q == IDLE) && reset_n;
  assign ic_req_ready = in_idle && !grant_dc;
  assign dc_req_ready = in_idle &&  grant_dc;
  assign ic_acc       = ic_req_ready && ic_req_valid;
  assign dc_acc       = dc_req_ready && dc_req_valid;

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    rd_wr_d = rd_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (dc_acc) begin
          addr_d  = dc_req_addr;
          rd_wr_d = dc_req_rd_wr;
          wdata_d = dc_req_wr_data;
          owner_d = OWN_DC;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else if (ic_acc) begin
          addr_d  = ic_req_addr;
          rd_wr_d = 1'b0;
          wdata_d = '0;
          owner_d = OWN_IC;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (!rd_wr_q) rdata_d = mem_rd_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the latched request and read data are reset too, because their values are visible on outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_DC;
      addr_q  <= '0;
      rd_wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rd_wr_q <= rd_wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign op_cycle = busy && (cnt_q == '0);

  // Write strobe qualified by op_en so memory can never see a stray write.
  assign mem_op_en   = op_cycle;
  assign mem_rd_wr   = op_cycle && rd_wr_q;
  assign mem_addr    = busy ? addr_q  : '0;
  assign mem_wr_data = busy ? wdata_q : '0;

  assign resp_data     = rdata_q;
  assign ic_resp_valid = (state_q == RESP) && (owner_q == OWN_IC);
  assign dc_resp_valid = (state_q == RESP) && (owner_q == OWN_DC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and random transactions against a
// transaction-level model, plus a MEM_LATENCY=1 instance.
module tb_mem_arbiter;
  import PARAMS_pkg::*;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        ic_req_valid, dc_req_valid, dc_req_rd_wr;
  logic [31:0] ic_req_addr, dc_req_addr, dc_req_wr_data;
  logic        ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid;
  logic [31:0] resp_data, mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd_wr, mem_op_en;

  logic        l1_ic_valid, l1_dc_valid, l1_dc_rd_wr;
  logic [31:0] l1_ic_addr, l1_dc_addr, l1_dc_wr_data;
  logic        l1_ic_ready, l1_dc_ready, l1_ic_resp, l1_dc_resp;
  logic [31:0] l1_resp_data, l1_mem_addr, l1_mem_wr_data, l1_mem_rd_data;
  logic        l1_mem_rd_wr, l1_mem_op_en;

  mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_rd_wr(dc_req_rd_wr),
    .dc_req_wr_data(dc_req_wr_data), .dc_req_ready(dc_req_ready),
    .ic_resp_valid(ic_resp_valid), .dc_resp_valid(dc_resp_valid), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr), .mem_op_en(mem_op_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(l1_ic_valid), .ic_req_addr(l1_ic_addr), .ic_req_ready(l1_ic_ready),
    .dc_req_valid(l1_dc_valid), .dc_req_addr(l1_dc_addr), .dc_req_rd_wr(l1_dc_rd_wr),
    .dc_req_wr_data(l1_dc_wr_data), .dc_req_ready(l1_dc_ready),
    .ic_resp_valid(l1_ic_resp), .dc_resp_valid(l1_dc_resp), .resp_data(l1_resp_data),
    .mem_addr(l1_mem_addr), .mem_rd_wr(l1_mem_rd_wr), .mem_op_en(l1_mem_op_en),
    .mem_wr_data(l1_mem_wr_data), .mem_rd_data(l1_mem_rd_data)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  // Memory behind the main instance: a fixed pattern overlaid by written words.
  logic [31:0] wmem [256];
  bit          written [256];
  always @(posedge clk) begin
    if (mem_op_en && mem_rd_wr) begin
      wmem[mem_addr[7:0]]    <= mem_wr_data;
      written[mem_addr[7:0]] <= 1'b1;
    end
  end
  assign mem_rd_data    = written[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : pat(mem_addr[7:0]);
  assign l1_mem_rd_data = pat(l1_mem_addr[7:0]);

  // Transaction-level reference: memory contents, last grant, last read value.
  logic [31:0] ref_mem [logic [31:0]];
  bit          last_dc;
  logic [31:0] exp_resp;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a[7:0]);
  endfunction

  function automatic bit model_grant_dc(input bit icv, input bit dcv);
    if (dcv && !icv) return 1'b1;
    if (icv && !dcv) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return !last_dc;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the arbiter idle; returns one negedge after the response.
  task automatic txn(input bit icv, input bit dcv, input bit rw,
                     input logic [7:0] ia, input logic [7:0] da, input logic [31:0] wd);
    bit          g_dc;
    bit          w;
    logic [31:0] a;
    ic_req_valid   = icv;
    dc_req_valid   = dcv;
    ic_req_addr    = 32'(ia);
    dc_req_addr    = 32'(da);
    dc_req_rd_wr   = rw;
    dc_req_wr_data = wd;
    g_dc = model_grant_dc(icv, dcv);
    #1;
    check("ic_req_ready", ic_req_ready, !g_dc);
    check("dc_req_ready", dc_req_ready, g_dc);
    last_dc = g_dc;
    a = g_dc ? 32'(da) : 32'(ia);
    w = g_dc && rw;
    if (w) ref_mem[a] = wd;
    else   exp_resp = ref_rd(a);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk); #1;
      check("ready_low", {30'd0, ic_req_ready, dc_req_ready}, 32'd0);
      check("mem_op_en", mem_op_en, k == LAT);
      check("mem_rd_wr", mem_rd_wr, (k == LAT) && w);
      if (k <= LAT) check("mem_addr", mem_addr, a);
      if (k == LAT && w) check("mem_wr_data", mem_wr_data, wd);
      check("ic_resp_valid", ic_resp_valid, (k == LAT + 1) && !g_dc);
      check("dc_resp_valid", dc_resp_valid, (k == LAT + 1) && g_dc);
      if (k == LAT + 1) check("resp_data", resp_data, exp_resp);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    {ic_req_valid, dc_req_valid, dc_req_rd_wr} = '0;
    {ic_req_addr, dc_req_addr, dc_req_wr_data} = '0;
    {l1_ic_valid, l1_dc_valid, l1_dc_rd_wr} = '0;
    {l1_ic_addr, l1_dc_addr, l1_dc_wr_data} = '0;
    last_dc  = 1'b0;
    exp_resp = '0;
    #1;
    check("rst_ready", {30'd0, ic_req_ready, dc_req_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, ic_resp_valid, dc_resp_valid}, 32'd0);
    check("rst_mem_ctl", {30'd0, mem_op_en, mem_rd_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr_data", mem_wr_data, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Tie for four transactions straight out of reset (first accept on first edge).
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 8'(8'h50 + i), 32'h0);

    // Single-requester reads and the write/read-back pair.
    txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 32'h0);
    txn(1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 32'h0);
    txn(1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 32'h0);

    // Idle with a valid that is withdrawn before any edge: nothing may start.
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b1;
    #2;
    dc_req_valid = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk); #1;
      check("idle_op_en", mem_op_en, 1'b0);
      check("idle_resp", {30'd0, ic_resp_valid, dc_resp_valid}, 32'd0);
    end

    // Reset three cycles into a read: transaction dropped, no response afterwards.
    dc_req_valid = 1'b1;
    dc_req_rd_wr = 1'b0;
    dc_req_addr  = 32'h30;
    #1;
    check("pre_rst_dc_ready", dc_req_ready, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("busy_before_rst", mem_addr, 32'h30);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {30'd0, ic_req_ready, dc_req_ready}, 32'd0);
    check("mid_rst_mem_ctl", {30'd0, mem_op_en, mem_rd_wr}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    exp_resp = '0;
    last_dc  = 1'b0;
    dc_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk); #1;
      check("post_rst_resp", {30'd0, ic_resp_valid, dc_resp_valid}, 32'd0);
      check("post_rst_op_en", mem_op_en, 1'b0);
    end
    txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h30, 32'h0);

    // Randomized mix of requesters, directions, addresses and data.
    for (int i = 0; i < 30; i++) begin
      bit icv, dcv;
      icv = 1'($urandom_range(0, 1));
      dcv = 1'($urandom_range(0, 1));
      if (!icv && !dcv) dcv = 1'b1;
      txn(icv, dcv, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)),
          8'($urandom_range(0, 63)), $urandom);
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;

    // Latency-1 instance with valid held high across the whole transaction.
    @(negedge clk);
    l1_dc_valid = 1'b1;
    l1_dc_addr  = 32'h07;
    #1;
    check("l1_accept_ready", l1_dc_ready, 1'b1);
    @(negedge clk); #1;
    check("l1_op_en", l1_mem_op_en, 1'b1);
    check("l1_busy_ready", {30'd0, l1_ic_ready, l1_dc_ready}, 32'd0);
    check("l1_busy_resp", l1_dc_resp, 1'b0);
    @(negedge clk); #1;
    check("l1_resp_valid", l1_dc_resp, 1'b1);
    check("l1_ic_resp", l1_ic_resp, 1'b0);
    check("l1_resp_data", l1_resp_data, pat(8'h07));
    check("l1_resp_ready", {30'd0, l1_ic_ready, l1_dc_ready}, 32'd0);
    check("l1_resp_op_en", l1_mem_op_en, 1'b0);
    @(negedge clk); #1;
    check("l1_idle_ready", l1_dc_ready, 1'b1);
    check("l1_idle_resp", l1_dc_resp, 1'b0);
    l1_dc_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 5, memory access latency in cycles (legal 1..15).
REQ-002 Parameters ADDR_SIZE, WD_SIZE, from PARAMS_pkg: address and data-word widths.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ic_req_valid  in  1  instruction-cache miss request (read only).
REQ-006 ic_req_addr  in  ADDR_SIZE  instruction-cache request address.
REQ-007 ic_req_ready  out  1  instruction-cache request accepted this cycle when valid.
REQ-008 dc_req_valid  in  1  data-cache request.
REQ-009 dc_req_addr  in  ADDR_SIZE  data-cache request address.
REQ-010 dc_req_rd_wr  in  1  1 = write, 0 = read.
REQ-011 dc_req_wr_data  in  WD_SIZE  write data.
REQ-012 dc_req_ready  out  1  data-cache request accepted this cycle when valid.
REQ-013 ic_resp_valid / dc_resp_valid  out  1 each  one-cycle response pulse to the owner.
REQ-014 resp_data  out  WD_SIZE  read data; shared by both requesters.
REQ-015 mem_addr, mem_rd_wr, mem_op_en, mem_wr_data  out  ADDR_SIZE/1/1/WD_SIZE  drive memory addr, rd_wr, op_en, wr_data.
REQ-016 mem_rd_data  in  WD_SIZE  memory read data (combinational from memory).

Function
REQ-017 FSM states IDLE, BUSY, RESP; only one memory transaction outstanding.
REQ-018 IDLE: grant computed combinationally; the granted requester's ready = 1, the other's = 0; both ready = 0 outside IDLE.
REQ-019 Handshake: valid & ready at an edge latches addr, rd_wr (0 for ic), wr_data, owner; IDLE -> BUSY, counter loaded with MEM_LATENCY-1.
REQ-020 No valid in IDLE: remain IDLE, no memory activity.
REQ-021 BUSY: counter decrements each cycle; mem_addr/mem_rd_wr/mem_wr_data driven from latched values throughout; mem_op_en = 1 only in the cycle the counter is 0.
REQ-022 BUSY with counter 0: at the edge capture mem_rd_data (reads only) into resp_data; BUSY -> RESP.
REQ-023 RESP: owner's resp_valid = 1 for exactly one cycle; resp_data valid for reads, unchanged for writes (write ack only); RESP -> IDLE.
REQ-024 Latency: resp_valid asserted exactly MEM_LATENCY+1 cycles after the accepting edge; back-to-back accepts spaced MEM_LATENCY+2 cycles.
REQ-025 Requester may drop or change valid while not accepted; no request is latched without handshake.
REQ-026 Inputs ignored in BUSY/RESP; resp_data holds its value until next read capture.
REQ-027 Outside the mem_op_en cycle, mem_rd_wr = 0 and mem_op_en = 0, so memory never writes spuriously.

Reset
REQ-028 reset_n low: immediately IDLE, counter 0, latched request cleared, owner = dc.
REQ-029 Reset values: all ready, resp_valid, mem_op_en, mem_rd_wr = 0; mem_addr, mem_wr_data, resp_data = 0.
REQ-030 Reset mid-BUSY/RESP: transaction discarded, no response pulse after reset release.
REQ-031 First accept possible at the first rising edge with reset_n high.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: round-robin; when both valid, grant goes to the requester not granted last; last-grant flag resets to ic (dc wins first tie).
REQ-033 MEM_ARB_RR_EN undefined: fixed priority, dc always wins a tie; ic granted only when dc_req_valid = 0.
REQ-034 Single-requester behaviour identical in both builds.

Verification (MEM_LATENCY = 5)
REQ-035 dc read addr 0x10, memory word 0xA5..: dc_req_ready = 1 at accept, mem_op_en high one cycle, dc_resp_valid pulse 6 cycles after accept with resp_data = memory word, ic_resp_valid stays 0.
REQ-036 dc write addr 0x20 data 0xDEADBEEF then dc read 0x20: write ack pulse at +6, read returns 0xDEADBEEF; second accept exactly 7 cycles after first.
REQ-037 ic and dc valid held together for 4 transactions: with MEM_ARB_RR_EN grants dc, ic, dc, ic; without it dc, dc, dc, dc and ic_req_ready never 1.
REQ-038 reset_n pulsed low during BUSY (cycle +3): all outputs 0 asynchronously, no resp_valid afterwards, next request completes normally.
REQ-039 MEM_LATENCY = 1: accept -> mem_op_en next cycle -> resp_valid at +2; ready low throughout BUSY/RESP despite valid held high.
